// File: rtl/count_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one up/down counter.
// Each grant is a fixed three-cycle transaction: IDLE -> PULSE -> SETTLE -> IDLE.
module count_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MAX_VAL = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           dir,
  input  logic [3:0]                 cnt_val,
  output logic                       count,
  output logic                       deCount,
  output logic [N_REQ-1:0]           ack,
  output logic                       sat_err,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int         IW    = $clog2(N_REQ);
  localparam logic [3:0] MAX_V = MAX_VAL[3:0];
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            dir_q, dir_d;
  logic            refused_q, refused_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            at_bound;

  // Search above last_grant first, then wrap to the low indices.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_found && req[i] && (i > int'(last_grant_q))) begin
        pick_found = 1'b1;
        pick_idx   = i[IW-1:0];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_found && req[i] && (i <= int'(last_grant_q))) begin
        pick_found = 1'b1;
        pick_idx   = i[IW-1:0];
      end
    end
  end

  assign at_bound = dir_q ? (cnt_val >= MAX_V) : (cnt_val == 4'd0);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dir_d        = dir_q;
    refused_d    = refused_q;
    last_grant_d = last_grant_q;
    count        = 1'b0;
    deCount      = 1'b0;
    ack          = '0;
    sat_err      = 1'b0;
    grant_id     = '0;
    busy         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          idx_d     = pick_idx;
          dir_d     = dir[pick_idx];
          refused_d = 1'b0;
          state_d   = PULSE;
        end
      end
      PULSE: begin
        busy      = 1'b1;
        grant_id  = idx_q;
        count     = dir_q && !at_bound;
        deCount   = !dir_q && !at_bound;
        refused_d = at_bound;
        state_d   = SETTLE;
      end
      SETTLE: begin
        busy         = 1'b1;
        grant_id     = idx_q;
        ack[idx_q]   = 1'b1;
        sat_err      = refused_q;
        last_grant_d = idx_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      dir_q        <= 1'b0;
      refused_q    <= 1'b0;
      last_grant_q <= LAST_IDX;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dir_q        <= dir_d;
      refused_q    <= refused_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_count_arbiter.sv
// Directed self-checking bench for count_arbiter with hand-computed expectations.
module tb_count_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] dir;
  logic [3:0] cnt_val;
  logic       count;
  logic       deCount;
  logic [3:0] ack;
  logic       sat_err;
  logic [1:0] grant_id;
  logic       busy;

  int checks = 0;
  int errors = 0;

  count_arbiter #(.N_REQ(4), .MAX_VAL(15)) dut (
    .clk(clk), .reset(reset), .req(req), .dir(dir), .cnt_val(cnt_val),
    .count(count), .deCount(deCount), .ack(ack), .sat_err(sat_err),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b0; req = '0; dir = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = '0; dir = '0; cnt_val = '0;
    repeat (2) begin
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if ({count, deCount, sat_err} !== 3'b000) begin errors++; $display("FAIL rst_strobes got=%b exp=000", {count, deCount, sat_err}); end
      checks++; if (ack !== 4'b0000 || grant_id !== 2'd0) begin errors++; $display("FAIL rst_ack_gid ack=%b gid=%0d exp ack=0000 gid=0", ack, grant_id); end
    end
    reset = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      checks++; if ({busy, count, deCount, sat_err, ack, grant_id} !== 10'd0) begin
        errors++; $display("FAIL idle_outputs got=%b exp=0", {busy, count, deCount, sat_err, ack, grant_id});
      end
    end
    $display("reset: idle outputs checked for 5 cycles");
  endtask

  task automatic test_single_up();
    cnt_val = 4'd3; req = 4'b0001; dir = 4'b0001;
    @(posedge clk); #1;
    checks++; if (count !== 1'b1 || deCount !== 1'b0) begin errors++; $display("FAIL single_pulse count=%b deCount=%b exp 1/0", count, deCount); end
    checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL single_busy busy=%b gid=%0d exp 1/0", busy, grant_id); end
    @(posedge clk); #1;
    checks++; if (ack !== 4'b0001 || sat_err !== 1'b0) begin errors++; $display("FAIL single_ack ack=%b sat=%b exp 0001/0", ack, sat_err); end
    checks++; if (count !== 1'b0 || deCount !== 1'b0) begin errors++; $display("FAIL single_settle_strobe count=%b deCount=%b exp 0/0", count, deCount); end
    req = '0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || ack !== 4'b0000) begin errors++; $display("FAIL single_idle busy=%b ack=%b exp 0/0000", busy, ack); end
    $display("single_up: cnt_val=3 up from req0 -> count pulse, ack=0001");
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    cnt_val = 4'd5; req = 4'b1111; dir = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      logic [3:0] exp_ack;
      exp_ack = 4'b0001 << exp_order[t];
      @(posedge clk); #1;
      checks++; if (grant_id !== 2'(exp_order[t]) || count !== 1'b1) begin
        errors++; $display("FAIL rr_grant t=%0d gid=%0d count=%b exp gid=%0d count=1", t, grant_id, count, exp_order[t]);
      end
      @(posedge clk); #1;
      checks++; if (ack !== exp_ack || $countones(ack) != 1) begin
        errors++; $display("FAIL rr_ack t=%0d ack=%b exp=%b", t, ack, exp_ack);
      end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || ack !== 4'b0000) begin
        errors++; $display("FAIL rr_idle t=%0d busy=%b ack=%b exp 0/0000", t, busy, ack);
      end
      $display("round_robin: transaction %0d granted=%0d ack=%b", t, grant_id, exp_ack);
    end
    req = '0;
  endtask

  task automatic run_one(input logic [3:0] r, input logic [3:0] d, input logic [3:0] cv,
                         input logic [1:0] exp_gid, input logic exp_cnt, input logic exp_dec,
                         input logic exp_sat, input string name);
    req = r; dir = d; cnt_val = cv;
    @(posedge clk); #1;
    checks++; if (grant_id !== exp_gid || count !== exp_cnt || deCount !== exp_dec) begin
      errors++; $display("FAIL %s_pulse gid=%0d count=%b deCount=%b exp %0d/%b/%b", name, grant_id, count, deCount, exp_gid, exp_cnt, exp_dec);
    end
    @(posedge clk); #1;
    checks++; if (ack !== (4'b0001 << exp_gid) || sat_err !== exp_sat) begin
      errors++; $display("FAIL %s_settle ack=%b sat_err=%b exp ack=%b sat_err=%b", name, ack, sat_err, 4'b0001 << exp_gid, exp_sat);
    end
    req = '0;
    @(posedge clk); #1;
    $display("%s: gid=%0d cnt_val=%0d sat_err_expected=%b", name, exp_gid, cv, exp_sat);
  endtask

  task automatic test_saturation();
    run_one(4'b0100, 4'b0100, 4'd15, 2'd2, 1'b0, 1'b0, 1'b1, "sat_top");
    run_one(4'b0010, 4'b0000, 4'd0,  2'd1, 1'b0, 1'b0, 1'b1, "sat_bottom");
    run_one(4'b1000, 4'b0000, 4'd7,  2'd3, 1'b0, 1'b1, 1'b0, "down_mid");
    run_one(4'b0001, 4'b0001, 4'd14, 2'd0, 1'b1, 1'b0, 1'b0, "up_near_top");
    run_one(4'b0100, 4'b0000, 4'd1,  2'd2, 1'b0, 1'b1, 1'b0, "down_near_bottom");
  endtask

  task automatic test_latched();
    req = 4'b0010; dir = 4'b0000; cnt_val = 4'd4;
    @(posedge clk); #1;
    req = 4'b0000; dir = 4'b1111;
    #1;
    checks++; if (deCount !== 1'b1 || count !== 1'b0) begin errors++; $display("FAIL latch_pulse count=%b deCount=%b exp 0/1", count, deCount); end
    @(posedge clk); #1;
    checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL latch_ack ack=%b exp=0010", ack); end
    @(posedge clk); #1;
    $display("latched: req1 dropped in PULSE, still acked");
    req = 4'b0001; dir = 4'b0001;
    @(posedge clk); #1;
    req = 4'b1001;
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL drop_grant gid=%0d exp=0", grant_id); end
    @(posedge clk); #1;
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL drop_ack0 ack=%b exp=0001", ack); end
    req = 4'b0000;
    repeat (6) begin
      @(posedge clk); #1;
      checks++; if (ack !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL drop_req3 ack=%b busy=%b exp 0000/0", ack, busy); end
    end
    $display("dropped: req3 withdrawn before grant, never acked");
  endtask

  task automatic test_reset_abort();
    req = 4'b0100; dir = 4'b0100; cnt_val = 4'd5;
    @(posedge clk); #1;
    checks++; if (count !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL abort_pre count=%b gid=%0d exp 1/2", count, grant_id); end
    reset = 1'b0;
    #1;
    checks++; if ({count, deCount, busy, sat_err} !== 4'b0000 || ack !== 4'b0000 || grant_id !== 2'd0) begin
      errors++; $display("FAIL abort_async count=%b deCount=%b busy=%b ack=%b gid=%0d exp all 0", count, deCount, busy, ack, grant_id);
    end
    @(posedge clk); #1;
    checks++; if (ack !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL abort_noack ack=%b busy=%b exp 0000/0", ack, busy); end
    reset = 1'b1; req = 4'b0101; dir = 4'b0101;
    @(posedge clk); #1;
    checks++; if (grant_id !== 2'd0 || count !== 1'b1) begin errors++; $display("FAIL abort_regrant gid=%0d count=%b exp 0/1", grant_id, count); end
    @(posedge clk); #1;
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL abort_regrant_ack ack=%b exp=0001", ack); end
    req = '0;
    @(posedge clk); #1;
    $display("reset_abort: PULSE aborted, next grant to requester 0");
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_round_robin();
    test_saturation();
    test_latched();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_arbiter.md
COUNT_ARBITER -- requirements
Module: count_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the up/down counter; legal range 2-8.
REQ-002 Parameter MAX_VAL, default 15, top value of the shared counter; the bottom value is 0.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 req  input  N_REQ  per-requester level request; held high until the matching ack.
REQ-006 dir  input  N_REQ  per-requester direction, 1 = increment, 0 = decrement; valid while the matching req is high.
REQ-007 cnt_val  input  4  current value of the shared counter's out bus.
REQ-008 count  output  1  one-cycle increment strobe to the counter.
REQ-009 deCount  output  1  one-cycle decrement strobe to the counter.
REQ-010 ack  output  N_REQ  one-hot, one-cycle completion pulse to the served requester.
REQ-011 sat_err  output  1  one-cycle flag, coincident with ack, when the served operation was refused at a bound.
REQ-012 grant_id  output  $clog2(N_REQ)  index of the requester currently being served; 0 when idle.
REQ-013 busy  output  1  high in every state other than IDLE.

Function
REQ-014 The FSM SHALL have three states, IDLE, PULSE and SETTLE, with one transaction taking exactly 3 cycles: IDLE -> PULSE -> SETTLE -> IDLE.
REQ-015 In IDLE with any req bit high, the block SHALL select one requester by round-robin, latch its index and dir, and go to PULSE on the next edge.
REQ-016 In IDLE with req == 0, the block SHALL stay in IDLE.
REQ-017 Round-robin: the search starts at index (last_grant+1) mod N_REQ and ascends with wrap-around; last_grant updates on the SETTLE->IDLE edge.
REQ-018 In PULSE, an increment request with cnt_val < MAX_VAL SHALL drive count=1.
REQ-019 In PULSE, a decrement request with cnt_val > 0 SHALL drive deCount=1.
REQ-020 In PULSE, an increment at cnt_val == MAX_VAL or a decrement at cnt_val == 0 SHALL drive neither strobe and SHALL set an internal refused flag.
REQ-021 count and deCount SHALL never be high in the same cycle, and each SHALL be high only in PULSE.
REQ-022 In SETTLE, ack[grant] SHALL be 1 for exactly that cycle, and sat_err SHALL equal the refused flag.
REQ-023 Latched index and dir SHALL govern the transaction; a change of req or dir after the grant SHALL NOT alter or cancel it.
REQ-024 A req that is still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-025 A req that drops before it is granted SHALL be dropped with no strobe and no ack.
REQ-026 grant_id SHALL hold the latched index in PULSE and SETTLE, and SHALL be 0 in IDLE.
REQ-027 cnt_val SHALL be sampled only in PULSE; it SHALL be ignored in all other states.

Reset
REQ-028 While reset == 0, the FSM SHALL be in IDLE, with count=0, deCount=0, ack=0, sat_err=0, busy=0 and grant_id=0.
REQ-029 Reset SHALL set last_grant = N_REQ-1, so requester 0 has highest priority after reset.
REQ-030 Reset asserted in PULSE or SETTLE SHALL abort the transaction at once: no strobe or ack completes, and the latched request is lost.
REQ-031 After reset deasserts, the first IDLE evaluation SHALL occur on the first rising edge.

Verification
REQ-032 reset=0 for 2 cycles, then 1, req=0 -> all outputs 0 and busy=0 for 5 cycles.
REQ-033 cnt_val=3, req=0001, dir=0001 -> count=1 in cycle 2, ack=0001 in cycle 3, sat_err=0, deCount stays 0.
REQ-034 req=1111 held, all up, cnt_val=5 -> grants issued in the order 0,1,2,3,0, one every 3 cycles, and exactly one ack per transaction.
REQ-035 cnt_val=15 with an up request from req[2] -> no count pulse, ack=0100 with sat_err=1; cnt_val=0 with a down request -> no deCount, sat_err=1.
REQ-036 req[1] drops during PULSE -> deCount/count is still issued and ack[1] still fires; req[3] high then low while another requester is served -> req[3] is never acked.
REQ-037 reset=0 asserted in a PULSE cycle -> count and deCount drop asynchronously, there is no ack, busy=0, and the next grant after release goes to requester 0.
